// File: rtl/frog_pkg.sv
// Shared types and constants for the frog / river-log logic.
package frog_pkg;

    localparam int NUM_LOGS = 9;

    typedef logic signed [10:0] coord_x_t;
    typedef logic [9:0]         coord_y_t;

    typedef coord_x_t log_x_arr_t [NUM_LOGS];
    typedef coord_y_t log_y_arr_t [NUM_LOGS];

    typedef enum logic [1:0] {
        ST_FREE   = 2'd0,
        ST_RIDING = 2'd1,
        ST_DYING  = 2'd2,
        ST_DEAD   = 2'd3
    } rider_state_t;

    // Sign-extend an x coordinate to 12 bits so sums near the screen edge cannot wrap.
    function automatic logic signed [11:0] sext_x(input coord_x_t v);
        return {v[10], v};
    endfunction

endpackage

// File: rtl/log_overlap.sv
// Combinational test of the frog's centre against every log; lowest index wins.
module log_overlap
    import frog_pkg::*;
#(
    parameter int LOG_W  = 96,
    parameter int FROG_W = 24
) (
    input  coord_x_t   frog_x,
    input  coord_y_t   frog_y,
    input  log_x_arr_t log_x,
    input  log_y_arr_t log_y,
    output logic       hit,
    output logic [3:0] hit_idx
);

    localparam logic signed [11:0] HALF_W = 12'(FROG_W / 2);
    localparam logic signed [11:0] SPAN   = 12'(LOG_W - 1);

    logic signed [11:0] cx_s;
    logic [NUM_LOGS-1:0] match_s;

    // Frog centre, compared against each log span in signed 12-bit arithmetic.
    always_comb begin
        cx_s = sext_x(frog_x) + HALF_W;
        for (int i = 0; i < NUM_LOGS; i++) begin
            match_s[i] = (frog_y == log_y[i]) &&
                         (sext_x(log_x[i]) <= cx_s) &&
                         (cx_s <= sext_x(log_x[i]) + SPAN);
        end
    end

    // Priority pick: scanning downward lets the lowest matching index overwrite the rest.
    always_comb begin
        hit     = 1'b0;
        hit_idx = 4'd0;
        for (int i = NUM_LOGS - 1; i >= 0; i--) begin
            hit_idx = match_s[i] ? 4'(i) : hit_idx;
            hit     = hit | match_s[i];
        end
    end

endmodule

// File: rtl/log_rider.sv
// Per-frame tracker: riding a log, safe, or drowning, with the death sequence
// held until the lives logic acknowledges it.
module log_rider
    import frog_pkg::*;
#(
    parameter int LOG_W        = 96,
    parameter int FROG_W       = 24,
    parameter int LOG_STEP     = 1,
    parameter int RIVER_Y_MIN  = 72,
    parameter int RIVER_Y_MAX  = 167,
    parameter int X_MAX        = 639,
    parameter int DEATH_FRAMES = 30
) (
    input  logic              frame_clk,
    input  logic              Reset_n,
    input  coord_x_t          frog_x,
    input  coord_y_t          frog_y,
    input  logic              frog_hopping,
    input  log_x_arr_t        log_x,
    input  log_y_arr_t        log_y,
    input  logic              respawn_ack,
    output logic              on_log,
    output logic [3:0]        log_idx,
    output logic signed [3:0] carry_dx,
    output logic              drown,
    output logic              dying,
    output logic              dead
);

    localparam int CNT_W = $clog2(DEATH_FRAMES + 1);
    localparam logic [CNT_W-1:0]   DEATH_LOAD = CNT_W'(DEATH_FRAMES - 1);
    localparam logic [CNT_W-1:0]   CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic signed [11:0] EDGE_OFF   = 12'(FROG_W - 1 + LOG_STEP);
    localparam logic signed [11:0] X_LIMIT    = 12'(X_MAX);
    localparam logic signed [3:0]  STEP_DX    = 4'(LOG_STEP);

    rider_state_t      state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [3:0]        idx_d;
    logic              hit_s;
    logic [3:0]        hit_idx_s;
    logic              in_river_s;
    logic              off_edge_s;

    logic              on_log_q, drown_q, dying_q, dead_q;
    logic [3:0]        log_idx_q;
    logic signed [3:0] carry_dx_q;

    log_overlap #(
        .LOG_W  (LOG_W),
        .FROG_W (FROG_W)
    ) u_overlap (
        .frog_x  (frog_x),
        .frog_y  (frog_y),
        .log_x   (log_x),
        .log_y   (log_y),
        .hit     (hit_s),
        .hit_idx (hit_idx_s)
    );

    assign in_river_s = (frog_y >= 10'(RIVER_Y_MIN)) && (frog_y <= 10'(RIVER_Y_MAX));
    // Right edge after this frame's carry would leave the visible area.
    assign off_edge_s = (sext_x(frog_x) + EDGE_OFF) > X_LIMIT;

    // Next-state logic; the death counter loads on every entry into DYING.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = 4'd0;
        case (state_q)
            ST_FREE: begin
                if (frog_hopping) begin
                    state_d = ST_FREE;
                end else if (hit_s) begin
                    state_d = ST_RIDING;
                    idx_d   = hit_idx_s;
                end else if (in_river_s) begin
                    state_d = ST_DYING;
                    cnt_d   = DEATH_LOAD;
                end else begin
                    state_d = ST_FREE;
                end
            end
            ST_RIDING: begin
                if (frog_hopping) begin
                    state_d = ST_FREE;
                end else if (!hit_s || off_edge_s) begin
                    state_d = ST_DYING;
                    cnt_d   = DEATH_LOAD;
                end else begin
                    state_d = ST_RIDING;
                    idx_d   = hit_idx_s;
                end
            end
            ST_DYING: begin
                if (cnt_q == CNT_ZERO) begin
                    state_d = ST_DEAD;
                end else begin
                    cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_DEAD: begin
                if (respawn_ack) begin
                    state_d = ST_FREE;
                end else begin
                    state_d = ST_DEAD;
                end
            end
            default: begin
                state_d = ST_FREE;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // State, counter and registered outputs; outputs reflect the state being entered.
    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= ST_FREE;
            cnt_q      <= CNT_ZERO;
            on_log_q   <= 1'b0;
            log_idx_q  <= 4'd0;
            carry_dx_q <= 4'sd0;
            drown_q    <= 1'b0;
            dying_q    <= 1'b0;
            dead_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            on_log_q   <= (state_d == ST_RIDING);
            log_idx_q  <= idx_d;
            carry_dx_q <= (state_d == ST_RIDING) ? STEP_DX : 4'sd0;
            drown_q    <= (state_d == ST_DYING) && (state_q != ST_DYING);
            dying_q    <= (state_d == ST_DYING);
            dead_q     <= (state_d == ST_DEAD);
        end
    end

    assign on_log   = on_log_q;
    assign log_idx  = log_idx_q;
    assign carry_dx = carry_dx_q;
    assign drown    = drown_q;
    assign dying    = dying_q;
    assign dead     = dead_q;

endmodule
